adc_spi_reader: RTL and testbench

ADC_SPI_READER -- requirements
Module: adc_spi_reader

---
 rtl/adc_spi_reader.sv | 110 +++++++++++
 tb/tb_adc_spi_reader.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_reader.sv
// adc_spi_reader: SPI master that reads 12-bit conversions from a serial ADC
// Ports:
//   clk, rst         - system clock, synchronous active-high reset
//   start            - request one conversion (sampled in IDLE only)
//   continuous       - restart automatically after every frame
//   channel[2:0]     - ADC input channel, latched at frame start
//   adc_cs_n         - ADC chip select (active-low)
//   adc_sclk         - ADC serial clock (idles high)
//   adc_din          - address bits to the ADC
//   adc_dout         - conversion bits from the ADC
//   data[11:0]       - last completed conversion
//   valid            - one-clk pulse when data updates
//   busy             - high from frame start until back in IDLE
module adc_spi_reader #(
    parameter int         CLK_DIV    = 25,
    parameter logic [2:0] DEFAULT_CH = 3'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        continuous,
    input  logic [2:0]  channel,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    output logic        adc_din,
    input  logic        adc_dout,
    output logic [11:0] data,
    output logic        valid,
    output logic        busy
);
    localparam int CW = $clog2(CLK_DIV);
    typedef enum logic [1:0] {IDLE, XFER, DONE, QUIET} state_t;
    state_t      r_state;
    logic [CW-1:0] r_cnt;
    logic [4:0]  r_half;
    logic [2:0]  r_ch;
    logic [11:0] r_shift;
    logic        w_tick;
    logic [3:0]  w_k;
    logic        w_din;
    assign w_tick = r_cnt == CW'(CLK_DIV - 1);
    assign w_k    = r_half[4:1];
    // address bits go out MSB first on bit slots 2..4, zeros elsewhere
    assign w_din  = (w_k == 4'd2) ? r_ch[2] : (w_k == 4'd3) ? r_ch[1] : (w_k == 4'd4) ? r_ch[0] : 1'b0;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_half   <= '0;
            r_ch     <= DEFAULT_CH;
            r_shift  <= '0;
            adc_cs_n <= 1'b1;
            adc_sclk <= 1'b1;
            adc_din  <= 1'b0;
            data     <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (r_state)
                IDLE: if (start | continuous) begin
                    r_state  <= XFER;
                    r_ch     <= channel;
                    r_cnt    <= '0;
                    r_half   <= '0;
                    adc_cs_n <= 1'b0;
                    busy     <= 1'b1;
                end
                XFER: begin
                    r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
                    // even half-periods end in a falling edge, odd ones in a rising edge
                    if (w_tick) begin
                        r_half <= r_half + 1'b1;
                        if (!r_half[0]) begin
                            adc_sclk <= 1'b0;
                            adc_din  <= w_din;
                        end else begin
                            adc_sclk <= 1'b1;
                            // leading 4 bits fall off the top after 16 shifts
                            r_shift  <= {r_shift[10:0], adc_dout};
                            if (r_half == 5'd31) r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    data     <= r_shift;
                    valid    <= 1'b1;
                    adc_cs_n <= 1'b1;
                    adc_sclk <= 1'b1;
                    adc_din  <= 1'b0;
                    r_cnt    <= '0;
                    r_half   <= '0;
                    r_state  <= QUIET;
                end
                QUIET: begin
                    r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
                    // two counter wraps give the 2*CLK_DIV quiet gap
                    if (w_tick) begin
                        r_half <= 5'd1;
                        if (r_half[0]) begin
                            r_state <= IDLE;
                            busy    <= 1'b0;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_spi_reader.sv
// tb_adc_spi_reader: self-checking bench for adc_spi_reader with an ADC model and scoreboard
module tb_adc_spi_reader;
    logic clk = 0, rst = 1, start = 0, continuous = 0, adc_dout = 0;
    logic [2:0] channel = 0;
    logic adc_cs_n, adc_sclk, adc_din, valid, busy;
    logic [11:0] data;
    logic d_start = 0;
    logic d_cs_n, d_sclk, d_din, d_valid, d_busy;
    logic [11:0] d_data;
    int checks = 0, passes = 0, cyc = 0, vcount = 0, e0 = 0, kk = 0;
    logic [15:0] cur, din_cap;
    logic [15:0] model_q[$];
    logic [11:0] exp_q[$];
    int vt_q[$];
    typedef struct {logic [2:0] ch; logic [3:0] lead; logic [11:0] word; logic [11:0] exp_d;} vec_t;
    vec_t vecs[5];

    adc_spi_reader #(.CLK_DIV(2), .DEFAULT_CH(3'd0)) u_dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous), .channel(channel),
        .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .adc_din(adc_din), .adc_dout(adc_dout),
        .data(data), .valid(valid), .busy(busy));

    adc_spi_reader u_def (
        .clk(clk), .rst(rst), .start(d_start), .continuous(1'b0), .channel(3'd0),
        .adc_cs_n(d_cs_n), .adc_sclk(d_sclk), .adc_din(d_din), .adc_dout(1'b1),
        .data(d_data), .valid(d_valid), .busy(d_busy));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    endtask

    always @(negedge adc_cs_n) begin
        cur = model_q.size() > 0 ? model_q.pop_front() : 16'h0;
        kk = 0;
        din_cap = 0;
    end
    always @(negedge adc_sclk) if (!adc_cs_n && kk < 16) begin
        adc_dout = cur[15-kk];
        kk++;
    end
    always @(posedge adc_sclk) if (!adc_cs_n) din_cap = {din_cap[14:0], adc_din};

    always @(negedge clk) if (valid) begin
        vcount++;
        vt_q.push_back(cyc);
        if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
        else chk("data", data, exp_q.pop_front());
    end

    task automatic run_start(input logic [2:0] ch);
        @(negedge clk);
        channel = ch;
        start = 1;
        e0 = cyc + 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_valid(input int n);
        int v0 = vcount;
        int t = 0;
        while (vcount == v0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (vcount == v0) chk("valid_timeout", 0, 1);
        else chk("latency", vt_q[vt_q.size()-1] - e0, n);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (busy) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        int v0, fall, rise, lastrise, vtd, low;
        logic prev;
        vecs[0] = '{3'd5, 4'h0, 12'hABC, 12'hABC};
        vecs[1] = '{3'd0, 4'h0, 12'h000, 12'h000};
        vecs[2] = '{3'd7, 4'h0, 12'hFFF, 12'hFFF};
        vecs[3] = '{3'd2, 4'hF, 12'h000, 12'h000};
        vecs[4] = '{3'd1, 4'hA, 12'h5A5, 12'h5A5};
        repeat (3) @(negedge clk);
        chk("rst_cs_n", adc_cs_n, 1);
        chk("rst_sclk", adc_sclk, 1);
        chk("rst_din", adc_din, 0);
        chk("rst_data", data, 0);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        rst = 0;
        repeat (20) @(negedge clk);
        chk("idle_stays", {busy, adc_cs_n, valid}, 3'b010);

        for (int i = 0; i < 5; i++) begin
            model_q.push_back({vecs[i].lead, vecs[i].word});
            exp_q.push_back(vecs[i].exp_d);
            run_start(vecs[i].ch);
            chk("busy_at_e0", {busy, adc_cs_n}, 2'b10);
            wait_valid(65);
            chk("din_bits", din_cap[13:11], vecs[i].ch);
            chk("cs_n_after_valid", adc_cs_n, 1);
            wait_idle();
        end

        model_q.push_back({4'h0, 12'h123});
        exp_q.push_back(12'h123);
        run_start(3'd5);
        while (cyc < e0 + 9) @(negedge clk);
        channel = 3;
        start = 1;
        @(negedge clk);
        start = 0;
        chk("busy_during_ignore", busy, 1);
        wait_valid(65);
        chk("ignore_din", din_cap[13:11], 5);
        wait_idle();
        v0 = vcount;
        repeat (100) @(negedge clk);
        chk("no_queued_frame", {vcount - v0, 31'(busy)}, 0);

        model_q.push_back({4'h0, 12'h777});
        run_start(3'd4);
        while (cyc < e0 + 19) @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("midrst_outs", {adc_cs_n, adc_sclk, busy, valid}, 4'b1100);
        chk("midrst_data", data, 0);
        rst = 0;
        v0 = vcount;
        repeat (100) @(negedge clk);
        chk("midrst_no_valid", vcount - v0, 0);
        model_q.push_back({4'h0, 12'h3C3});
        exp_q.push_back(12'h3C3);
        run_start(3'd6);
        wait_valid(65);
        wait_idle();

        v0 = vt_q.size();
        model_q.push_back(16'h0001);
        model_q.push_back(16'h0FFF);
        model_q.push_back(16'h0800);
        exp_q.push_back(12'h001);
        exp_q.push_back(12'hFFF);
        exp_q.push_back(12'h800);
        @(negedge clk);
        continuous = 1;
        for (int t = 0; t < 400 && vt_q.size() < v0 + 3; t++) @(negedge clk);
        continuous = 0;
        if (vt_q.size() < v0 + 3) chk("cont_timeout", vt_q.size() - v0, 3);
        else begin
            chk("cont_gap1", vt_q[v0+1] - vt_q[v0], 70);
            chk("cont_gap2", vt_q[v0+2] - vt_q[v0+1], 70);
        end
        wait_idle();
        repeat (100) @(negedge clk);
        chk("cont_stops", vt_q.size() - v0, 3);
        chk("cont_queue_empty", exp_q.size(), 0);

        @(negedge clk);
        d_start = 1;
        e0 = cyc + 1;
        @(negedge clk);
        d_start = 0;
        fall = 0; rise = 0; lastrise = 0; vtd = 0; low = 0; prev = 1;
        for (int t = 0; t < 900; t++) begin
            if (!d_cs_n) low++;
            if (prev && !d_sclk && fall == 0) fall = cyc - e0;
            if (!prev && d_sclk) begin
                if (rise == 0) rise = cyc - e0;
                lastrise = cyc - e0;
            end
            if (d_valid) begin
                vtd = cyc - e0;
                chk("def_data", d_data, 12'hFFF);
            end
            prev = d_sclk;
            @(negedge clk);
        end
        chk("def_first_fall", fall, 25);
        chk("def_first_rise", rise, 50);
        chk("def_last_rise", lastrise, 800);
        chk("def_valid_time", vtd, 801);
        chk("def_cs_low", low, 801);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
